// File: rtl/requant_pkg.sv
// Shared constants and helpers for the requantising truncator.
// Saturation bounds and stage-1 working width.
package requant_pkg;

  localparam int S1_GUARD_BITS = 1;

  function automatic int s1_width(input int din_w);
    return din_w + S1_GUARD_BITS;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane: round + arithmetic shift, then saturate or wrap.
// Holds lane data registers only; valid flags live in the top.
module requant_lane
  import requant_pkg::*;
#(
  parameter int DIN  = 32,
  parameter int DOUT = 8,
  parameter int SHW  = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ld1_i,
  input  logic            ld2_i,
  input  logic [SHW-1:0]  shift_i,
  input  logic            round_i,
  input  logic            sat_en_i,
  input  logic [DIN-1:0]  x_i,
  output logic [DOUT-1:0] dout_o,
  output logic            sat_o
);

  localparam int W1 = s1_width(DIN);
  localparam logic signed [W1-1:0] HI = W1'(sat_max(DOUT));
  localparam logic signed [W1-1:0] LO = W1'(sat_min(DOUT));

  logic signed [W1-1:0] x_ext;
  logic signed [W1-1:0] rnd;
  logic signed [W1-1:0] x_rnd;
  logic signed [W1-1:0] y_d;
  logic signed [W1-1:0] y_q;
  logic [DOUT-1:0]      dout_d;
  logic [DOUT-1:0]      dout_q;
  logic                 sat_d;
  logic                 sat_q;

  // Stage 1: optional half-up rounding, then arithmetic shift.
  // Large shifts collapse to the sign, independent of rounding.
  always_comb begin
    x_ext = {x_i[DIN-1], x_i};
    rnd   = '0;
    if (round_i && shift_i != '0)
      rnd = W1'(1) << (shift_i - SHW'(1));
    x_rnd = x_ext + rnd;
    if (32'(shift_i) >= DIN)
      y_d = x_ext[W1-1] ? '1 : '0;
    else
      y_d = x_rnd >>> shift_i;
  end

  // Stage 2: clamp to the output range or keep the low bits.
  always_comb begin
    dout_d = y_q[DOUT-1:0];
    sat_d  = 1'b0;
    if (sat_en_i) begin
      unique case (1'b1)
        (y_q > HI): begin
          dout_d = HI[DOUT-1:0];
          sat_d  = 1'b1;
        end
        (y_q < LO): begin
          dout_d = LO[DOUT-1:0];
          sat_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lane data registers, loaded only when a real beat moves.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_q    <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (ld1_i)
        y_q <= y_d;
      if (ld2_i) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/requant_truncator.sv
// Multi-lane requantiser: two-stage pipeline with valid/ready flow
// control and a sticky saturation event counter.
module requant_truncator
  import requant_pkg::*;
#(
  parameter int NUM_LANES         = 4,
  parameter int DATA_IN_BITWIDTH  = 32,
  parameter int DATA_OUT_BITWIDTH = 8,
  parameter int SHIFT_BITWIDTH    = 6,
  parameter int SAT_CNT_BITWIDTH  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [SHIFT_BITWIDTH-1:0] cfg_shift,
  input  logic cfg_round_en,
  input  logic cfg_sat_en,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NUM_LANES*DATA_IN_BITWIDTH-1:0] data_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_LANES*DATA_OUT_BITWIDTH-1:0] data_out,
  input  logic clear_stats,
  output logic [SAT_CNT_BITWIDTH-1:0] sat_count
);

  localparam int PW = $clog2(NUM_LANES + 1);
  localparam int CW = SAT_CNT_BITWIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX =
    {1'b0, {SAT_CNT_BITWIDTH{1'b1}}};

  logic adv;
  logic ld1;
  logic ld2;
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s1_sat_q, s1_sat_d;
  logic [NUM_LANES-1:0] lane_sat;
  logic [PW-1:0] pop;
  logic [CW-1:0] sum;
  logic [SAT_CNT_BITWIDTH-1:0] cnt_q, cnt_d;

  assign adv       = !s2_v_q || out_ready;
  assign in_ready  = adv;
  assign ld1       = adv && in_valid;
  assign ld2       = adv && s1_v_q;
  assign out_valid = s2_v_q;
  assign sat_count = cnt_q;

  // Valid flags shift forward on advance; sat mode rides with stage 1.
  always_comb begin
    s1_v_d   = s1_v_q;
    s2_v_d   = s2_v_q;
    s1_sat_d = s1_sat_q;
    if (adv) begin
      s1_v_d = in_valid;
      s2_v_d = s1_v_q;
    end
    if (ld1)
      s1_sat_d = cfg_sat_en;
  end

  // Count flagged lanes on output transfer; clear has priority.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++)
      pop = pop + PW'(lane_sat[i]);
    sum   = CW'(cnt_q) + CW'(pop);
    cnt_d = cnt_q;
    if (clear_stats)
      cnt_d = '0;
    else if (out_valid && out_ready)
      cnt_d = (sum > CNT_MAX) ? {SAT_CNT_BITWIDTH{1'b1}}
                              : sum[SAT_CNT_BITWIDTH-1:0];
  end

  // Control state and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_sat_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s1_sat_q <= s1_sat_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    requant_lane #(
      .DIN  (DATA_IN_BITWIDTH),
      .DOUT (DATA_OUT_BITWIDTH),
      .SHW  (SHIFT_BITWIDTH)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .ld1_i    (ld1),
      .ld2_i    (ld2),
      .shift_i  (cfg_shift),
      .round_i  (cfg_round_en),
      .sat_en_i (s1_sat_q),
      .x_i      (data_in[g*DATA_IN_BITWIDTH +: DATA_IN_BITWIDTH]),
      .dout_o   (data_out[g*DATA_OUT_BITWIDTH +: DATA_OUT_BITWIDTH]),
      .sat_o    (lane_sat[g])
    );
  end

endmodule

// File: tb/tb_requant_truncator.sv
// Bench for requant_truncator: arithmetic scoreboard model plus
// directed vectors with literal expectations.
module tb_requant_truncator;

  localparam int NL   = 4;
  localparam int DIN  = 32;
  localparam int DOUT = 8;
  localparam int SHW  = 6;
  localparam int SCW  = 16;
  localparam longint OMAX = 127;
  localparam longint OMIN = -128;
  localparam longint CMAX = 65535;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [SHW-1:0] cfg_shift = '0;
  logic cfg_round_en = 1'b0;
  logic cfg_sat_en = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NL*DIN-1:0] data_in = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [NL*DOUT-1:0] data_out;
  logic clear_stats = 1'b0;
  logic [SCW-1:0] sat_count;

  always #5 clk = ~clk;

  requant_truncator #(
    .NUM_LANES         (NL),
    .DATA_IN_BITWIDTH  (DIN),
    .DATA_OUT_BITWIDTH (DOUT),
    .SHIFT_BITWIDTH    (SHW),
    .SAT_CNT_BITWIDTH  (SCW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_shift    (cfg_shift),
    .cfg_round_en (cfg_round_en),
    .cfg_sat_en   (cfg_sat_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .clear_stats  (clear_stats),
    .sat_count    (sat_count)
  );

  typedef struct {
    logic [NL*DOUT-1:0] d;
    int nsat;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  longint mcnt = 0;
  logic stall_prev = 1'b0;
  logic [NL*DOUT-1:0] stall_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Real-number view: floor((x + half) / 2^s), then range clamp.
  function automatic logic [DOUT:0] lane_model(input longint x,
      input int s, input bit r, input bit sat);
    longint y;
    if (s >= DIN) begin
      y = (x < 0) ? -1 : 0;
    end else begin
      y = x;
      if (r && s > 0)
        y = y + (longint'(1) <<< (s - 1));
      y = y >>> s;
    end
    if (sat && y > OMAX) return {1'b1, 8'h7F};
    if (sat && y < OMIN) return {1'b1, 8'h80};
    return {1'b0, y[7:0]};
  endfunction

  function automatic beat_t beat_model(input logic [NL*DIN-1:0] din,
      input int s, input bit r, input bit sat);
    beat_t b;
    logic signed [DIN-1:0] xs;
    logic [DOUT:0] lr;
    b.d = '0;
    b.nsat = 0;
    for (int i = 0; i < NL; i++) begin
      xs = din[i*DIN +: DIN];
      lr = lane_model(longint'(xs), s, r, sat);
      b.d[i*DOUT +: DOUT] = lr[DOUT-1:0];
      b.nsat += int'(lr[DOUT]);
    end
    return b;
  endfunction

  // Compare process: sample mid-cycle, predict the next edge.
  always @(negedge clk) begin
    beat_t e;
    if (!reset_n) begin
      sb.delete();
      mcnt = 0;
      stall_prev = 1'b0;
    end else begin
      chk("sat_count", 64'(sat_count), 64'(mcnt));
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(data_out), 64'(stall_data));
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      else
        chk("in_ready", 64'(in_ready), 64'd1);
      if (sb.size() == 0)
        chk("spurious_out", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        n_out++;
        chk("data_out", 64'(data_out), 64'(e.d));
        if (!clear_stats) begin
          mcnt = mcnt + e.nsat;
          if (mcnt > CMAX) mcnt = CMAX;
        end
      end
      if (clear_stats) mcnt = 0;
      stall_prev = out_valid && !out_ready;
      stall_data = data_out;
      if (in_valid && in_ready)
        sb.push_back(beat_model(data_in, int'(cfg_shift),
                                cfg_round_en, cfg_sat_en));
    end
  end

  task automatic beat_once(input logic [NL*DIN-1:0] d, input int s,
      input bit r, input bit sat, input bit clr,
      output logic [NL*DOUT-1:0] dout, output logic [SCW-1:0] cnt);
    @(posedge clk); #1;
    data_in = d;
    cfg_shift = SHW'(s);
    cfg_round_en = r;
    cfg_sat_en = sat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_stage1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_stage2", 64'(out_valid), 64'd1);
    dout = data_out;
    clear_stats = clr;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    cnt = sat_count;
  endtask

  function automatic logic [NL*DIN-1:0] pack(input int l3, input int l2,
      input int l1, input int l0);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*DOUT-1:0] dv;
    logic [SCW-1:0] cv;
    int base;
    int t;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    beat_once(pack(0, 0, -392, 392), 4, 1, 1, 0, dv, cv);
    chk("round_pos", 64'(dv[7:0]), 64'h19);
    chk("round_neg", 64'(dv[15:8]), 64'hE8);
    beat_once(pack(0, 0, -392, 392), 4, 0, 1, 0, dv, cv);
    chk("trunc_pos", 64'(dv[7:0]), 64'h18);
    chk("trunc_neg", 64'(dv[15:8]), 64'hE7);

    beat_once(pack(0, 0, -4096, 4096), 4, 0, 1, 0, dv, cv);
    chk("sat_hi", 64'(dv[7:0]), 64'h7F);
    chk("sat_lo", 64'(dv[15:8]), 64'h80);
    chk("sat_cnt2", 64'(cv), 64'd2);
    beat_once(pack(0, 0, -4096, 4096), 4, 0, 0, 0, dv, cv);
    chk("wrap_hi", 64'(dv[7:0]), 64'h00);
    chk("wrap_lo", 64'(dv[15:8]), 64'h00);
    chk("wrap_cnt", 64'(cv), 64'd2);

    for (int r = 0; r < 2; r++) begin
      beat_once(pack(32'h7FFFFFFF, 32'h80000000, 5, -5), 40, r[0], 1,
                0, dv, cv);
      chk("shift40_neg", 64'(dv[7:0]), 64'hFF);
      chk("shift40_pos", 64'(dv[15:8]), 64'h00);
    end
    beat_once(pack(32'h7FFFFFFF, 32'h80000000, 0, 0), 31, 1, 1, 0,
              dv, cv);
    chk("shift31_min", 64'(dv[23:16]), 64'hFF);

    @(posedge clk); #1;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          data_in = pack(i * 37 - 200, -i * 5000, i * 123457, i * 3 + 1);
          cfg_shift = SHW'((i * 7) % 41);
          cfg_round_en = i[0];
          cfg_sat_en = i[1];
          in_valid = 1'b1;
          t = 0;
          @(negedge clk);
          while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
          end
          if (t >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_count", 64'(n_out - base), 64'd10);

    @(posedge clk); #1;
    out_ready = 1'b0;
    cfg_sat_en = 1'b1;
    cfg_shift = 6'd4;
    cfg_round_en = 1'b0;
    data_in = pack(4096, 4096, -4096, 4096);
    in_valid = 1'b1;
    @(posedge clk); #1;
    data_in = pack(-4096, 4096, 4096, 4096);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(sat_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", 64'(out_valid), 64'd0);
    end

    beat_once(pack(0, 0, -4096, 4096), 4, 0, 1, 0, dv, cv);
    chk("pre_clr_cnt", 64'(cv), 64'd2);
    beat_once(pack(0, 0, -4096, 4096), 4, 0, 1, 1, dv, cv);
    chk("clr_collide", 64'(cv), 64'd0);

    @(posedge clk); #1;
    data_in = pack(-4096, 4096, -4096, 4096);
    cfg_shift = 6'd4;
    cfg_sat_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    repeat (16390) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("cnt_stick_max", 64'(sat_count), 64'hFFFF);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/requant_truncator.md
REQUANT_TRUNCATOR -- requirements
Module: requant_truncator

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: independent lanes per beat.
REQ-002 SHALL have parameter DATA_IN_BITWIDTH, default 32: signed input width per lane.
REQ-003 SHALL have parameter DATA_OUT_BITWIDTH, default 8: signed output width per lane; must be less than or equal to DATA_IN_BITWIDTH.
REQ-004 SHALL have parameter SHIFT_BITWIDTH, default 6: width of the runtime shift amount.
REQ-005 SHALL have parameter SAT_CNT_BITWIDTH, default 16: width of the saturation event counter.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 cfg_shift  in  SHIFT_BITWIDTH  arithmetic right-shift amount, unsigned.
REQ-009 cfg_round_en  in  1  enables round-half-up before the shift.
REQ-010 cfg_sat_en  in  1  1 = saturate to output range; 0 = keep LSBs (wrap).
REQ-011 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-012 data_in  in  NUM_LANES*DATA_IN_BITWIDTH  packed lanes; lane 0 in the LSBs.
REQ-013 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-014 data_out  out  NUM_LANES*DATA_OUT_BITWIDTH  packed results; lane 0 in the LSBs.
REQ-015 clear_stats  in  1  synchronously zeroes sat_count.
REQ-016 sat_count  out  SAT_CNT_BITWIDTH  running count of saturated lanes; sticks at its maximum.

Function
REQ-017 A beat SHALL transfer on the input when in_valid and in_ready are both high, and on the output when out_valid and out_ready are both high.
REQ-018 Pipeline depth SHALL be two registered stages.
- Stage 1: round and shift.
- Stage 2: saturate or wrap.
- Latency is 2 cycles from input transfer to out_valid when there is no stall.
REQ-019 Pipeline advance SHALL be advance = !out_valid || out_ready, with in_ready = advance; on a stall every stage holds its contents.
REQ-020 Full throughput SHALL be one beat per cycle while out_ready is high.
REQ-021 cfg_shift, cfg_round_en and cfg_sat_en SHALL be captured with each beat in stage 1, so a configuration change affects only beats accepted afterwards.
REQ-022 Stage-1 arithmetic SHALL be performed at DATA_IN_BITWIDTH+1 bits: x' = x + 2^(s-1) when rounding is enabled and s>0, then y = x' >>> s (arithmetic shift).
REQ-023 Rounding SHALL be half toward +infinity: 24.5 rounds to 25; -24.5 rounds to -24.
REQ-024 When s >= DATA_IN_BITWIDTH, the stage-1 result SHALL be 0 for non-negative x and -1 for negative x, regardless of rounding.
REQ-025 With cfg_sat_en=1, stage 2 SHALL clamp y to [-2^(DATA_OUT_BITWIDTH-1), 2^(DATA_OUT_BITWIDTH-1)-1] and flag each clamped lane as a saturation event.
REQ-026 With cfg_sat_en=0, stage 2 SHALL output y[DATA_OUT_BITWIDTH-1:0] and flag no events.
REQ-027 sat_count SHALL increase by the number of flagged lanes in each beat that transfers on the output, and SHALL saturate at 2^SAT_CNT_BITWIDTH-1.
REQ-028 When clear_stats and a counting output transfer occur in the same cycle, clear SHALL win: sat_count becomes 0 and that beat's events are dropped.
REQ-029 data_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 An in_valid that drops without a transfer SHALL leave no trace in the pipeline.

Reset
REQ-031 While reset_n=0 at a clock edge, out_valid, both stage valid flags, data_out and sat_count SHALL become 0.
REQ-032 in_ready SHALL be 1 from the first cycle after reset is released.
REQ-033 A reset asserted mid-stream SHALL discard all in-flight beats without emitting them.

Structure
REQ-034 A shared package requant_pkg SHALL hold:
- the saturation min/max constant functions parameterised by width;
- the stage-1 intermediate width constant.
REQ-035 Per-lane arithmetic SHALL live in one sub-module, requant_lane, instantiated NUM_LANES times.
- requant_lane contains the stage-1 and stage-2 data registers, without valid flags.
- Valid/ready control and the counter stay in requant_truncator.

Verification (defaults: NUM_LANES=4, DATA_IN_BITWIDTH=32, DATA_OUT_BITWIDTH=8)
REQ-036 Rounding: lane0=392, shift=4, round=1 -> 0x19 (25); with round=0 -> 0x18; lane1=-392 with round=1 -> 0xE8 (-24).
REQ-037 Saturation: lane0=4096, lane1=-4096, shift=4, sat=1 -> 0x7F, 0x80, sat_count=2; same input with sat=0 -> 0x00, 0x00, sat_count unchanged.
REQ-038 Shift bound: shift=40, lane0=-5 -> 0xFF; lane1=5 -> 0x00, with or without rounding.
REQ-039 Backpressure: 10 back-to-back beats, out_ready held low for cycles 3-5 -> in_ready low during the stall, all 10 results in order, no duplicates, data_out stable while stalled.
REQ-040 Reset mid-stream: reset_n low for 1 cycle with 2 beats in flight -> neither beat emitted; out_valid=0 and sat_count=0 next cycle; in_ready=1 after release.
REQ-041 Clear collision: clear_stats asserted in the same cycle as a saturating output transfer -> sat_count=0 on the next cycle.
